// File: rtl/ahb_bram_ctrl.sv
// AHB-Lite slave in front of a dual-port BRAM: byte-lane writes, registered reads, zero wait states.
// Optional AHB_BRAM_FWD_EN forwards write data into a colliding read; otherwise that read stalls.
module ahb_bram_ctrl #(
    parameter int unsigned ADDR_WIDTH = 12
) (
    input  logic                  clka,
    input  logic                  rst,
    input  logic                  HSEL,
    input  logic [31:0]           HADDR,
    input  logic [1:0]            HTRANS,
    input  logic [2:0]            HSIZE,
    input  logic                  HWRITE,
    input  logic [31:0]           HWDATA,
    input  logic                  HREADY,
    output logic                  HREADYOUT,
    output logic [31:0]           HRDATA,
    output logic                  HRESP,
    output logic [ADDR_WIDTH-1:0] addra,
    output logic [31:0]           dina,
    output logic [3:0]            wea,
    output logic [ADDR_WIDTH-1:0] addrb,
    input  logic [31:0]           doutb
);

    typedef enum logic [1:0] {
        StIdle,
        StWData,
`ifndef AHB_BRAM_FWD_EN
        StRData,
        StRStall
`else
        StRData
`endif
    } state_e;

    state_e                  r_state;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [3:0]              r_mask;

    logic                    w_accept;
    logic                    w_hazard;
    logic [ADDR_WIDTH-1:0]   w_idx;
    logic [3:0]              w_mask;
    logic                    w_unused;

    assign w_idx    = HADDR[ADDR_WIDTH+1:2];
    assign w_accept = HSEL & HTRANS[1] & HREADY;
    // Read colliding with the write whose data is on the bus this very cycle.
    assign w_hazard = w_accept & ~HWRITE & (r_state == StWData) & (w_idx == r_addr);
    assign w_unused = ^{HTRANS[0], HADDR[31:ADDR_WIDTH+2]};

    always_comb begin
        w_mask = 4'b1111;
        case (HSIZE)
            3'd0:    w_mask = 4'b0001 << HADDR[1:0];
            3'd1:    w_mask = HADDR[1] ? 4'b1100 : 4'b0011;
            default: w_mask = 4'b1111;
        endcase
    end

    always_ff @(posedge clka) begin
        if (rst) begin
            r_state <= StIdle;
            r_addr  <= '0;
            r_mask  <= '0;
        end else begin
            if (w_accept) begin
                r_addr <= w_idx;
                r_mask <= w_mask;
            end
`ifndef AHB_BRAM_FWD_EN
            if (r_state == StRStall) begin
                r_state <= StRData;
            end else if (w_hazard) begin
                r_state <= StRStall;
            end else
`endif
            if (w_accept) begin
                r_state <= HWRITE ? StWData : StRData;
            end else begin
                r_state <= StIdle;
            end
        end
    end

`ifdef AHB_BRAM_FWD_EN
    logic [31:0] r_fwd_data;
    logic [3:0]  r_fwd_mask;
    logic        r_fwd_hit;

    always_ff @(posedge clka) begin
        if (rst) begin
            r_fwd_data <= '0;
            r_fwd_mask <= '0;
            r_fwd_hit  <= 1'b0;
        end else begin
            r_fwd_hit <= w_hazard;
            if (w_hazard) begin
                r_fwd_data <= HWDATA;
                r_fwd_mask <= r_mask;
            end
        end
    end

    assign HREADYOUT = 1'b1;
    assign addrb     = rst ? '0 : w_idx;

    always_comb begin
        HRDATA = '0;
        if (r_state == StRData) begin
            HRDATA = doutb;
            for (int i = 0; i < 4; i++) begin
                if (r_fwd_hit && r_fwd_mask[i]) begin
                    HRDATA[8*i +: 8] = r_fwd_data[8*i +: 8];
                end
            end
        end
    end
`else
    assign HREADYOUT = (r_state != StRStall);
    // During the stall, re-read the word so the RAM returns the post-write value.
    assign addrb     = rst ? '0 : ((r_state == StRStall) ? r_addr : w_idx);
    assign HRDATA    = (r_state == StRData) ? doutb : '0;
`endif

    assign HRESP = 1'b0;
    assign addra = r_addr;
    assign wea   = (r_state == StWData) ? r_mask : 4'b0000;
    assign dina  = (r_state == StWData) ? HWDATA : 32'h0;

endmodule

// File: tb/tb_ahb_bram_ctrl.sv
// Scoreboard bench for ahb_bram_ctrl with a behavioural read-first dual-port RAM.
module tb_ahb_bram_ctrl;

    localparam int unsigned AW = 12;

    logic          clka = 1'b0;
    logic          rst;
    logic          HSEL;
    logic [31:0]   HADDR;
    logic [1:0]    HTRANS;
    logic [2:0]    HSIZE;
    logic          HWRITE;
    logic [31:0]   HWDATA;
    logic          HREADY;
    logic          HREADYOUT;
    logic [31:0]   HRDATA;
    logic          HRESP;
    logic [AW-1:0] addra;
    logic [31:0]   dina;
    logic [3:0]    wea;
    logic [AW-1:0] addrb;
    logic [31:0]   doutb;

    ahb_bram_ctrl #(.ADDR_WIDTH(AW)) u_dut (
        .clka      (clka),
        .rst       (rst),
        .HSEL      (HSEL),
        .HADDR     (HADDR),
        .HTRANS    (HTRANS),
        .HSIZE     (HSIZE),
        .HWRITE    (HWRITE),
        .HWDATA    (HWDATA),
        .HREADY    (HREADY),
        .HREADYOUT (HREADYOUT),
        .HRDATA    (HRDATA),
        .HRESP     (HRESP),
        .addra     (addra),
        .dina      (dina),
        .wea       (wea),
        .addrb     (addrb),
        .doutb     (doutb)
    );

    always #5 clka = ~clka;
    assign HREADY = HREADYOUT;  // single-slave bus

    logic [31:0] ram     [0:(1<<AW)-1];
    logic [31:0] ref_mem [0:(1<<AW)-1];

    // Read-first RAM: same-edge collision returns the old word.
    always @(posedge clka) begin
        for (int i = 0; i < 4; i++) begin
            if (wea[i]) ram[addra][8*i +: 8] <= dina[8*i +: 8];
        end
        doutb <= ram[addrb];
    end

    typedef struct {
        logic [AW-1:0] idx;
        logic [3:0]    mask;
        logic [31:0]   data;
    } wr_exp_t;

    typedef struct {
        logic [31:0] data;
        bit          stall;
    } rd_exp_t;

    wr_exp_t wr_q[$];
    rd_exp_t rd_q[$];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] a);
        case (size)
            3'd0:    return 4'b0001 << a;
            3'd1:    return a[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    logic [31:0]   pend_wdata = '0;
    bit            prev_wr    = 0;
    logic [AW-1:0] prev_idx   = '0;

    // One AHB address phase; also carries the previous write's data phase.
    task automatic ahb(input bit sel, input bit [1:0] trans, input bit wr, input logic [31:0] addr,
                       input logic [2:0] size, input logic [31:0] wdata);
        bit            rdy;
        bit            acc;
        bit            stall;
        int            n;
        logic [AW-1:0] idx;
        logic [3:0]    m;
        idx    = addr[AW+1:2];
        m      = lane_mask(size, addr[1:0]);
        acc    = sel && trans[1];
        HSEL   = sel;
        HTRANS = trans;
        HWRITE = wr;
        HADDR  = addr;
        HSIZE  = size;
        HWDATA = pend_wdata;
        if (acc) begin
            if (wr) begin
                wr_q.push_back('{idx, m, wdata});
                for (int i = 0; i < 4; i++) begin
                    if (m[i]) ref_mem[idx][8*i +: 8] = wdata[8*i +: 8];
                end
            end else begin
`ifdef AHB_BRAM_FWD_EN
                stall = 0;
`else
                stall = prev_wr && (prev_idx == idx);
`endif
                rd_q.push_back('{ref_mem[idx], stall});
            end
        end
        rdy = 0;
        n   = 0;
        while (!rdy && n < 8) begin
            @(negedge clka);
            rdy = HREADYOUT;
            @(posedge clka);
            #1;
            n++;
        end
        if (!rdy) check("accept_timeout", {31'b0, HREADYOUT}, 32'd1);
        pend_wdata = (acc && wr) ? wdata : '0;
        prev_wr    = acc && wr;
        prev_idx   = idx;
    endtask

    task automatic idle();
        ahb(0, 2'b00, 0, 32'h0, 3'd2, 32'h0);
    endtask

    // Monitor: tracks the AHB data phase and pops the scoreboard.
    int dp         = 0;  // 0 none, 1 write, 2 read
    bit stall_seen = 0;

    always @(negedge clka) begin
        if (rst) begin
            dp         = 0;
            stall_seen = 0;
        end else begin
            if (dp == 1) begin
                if (wr_q.size() == 0) begin
                    check("wr_q_underflow", wr_q.size(), 32'd1);
                end else begin
                    check("wea", {28'b0, wea}, {28'b0, wr_q[0].mask});
                    check("addra", {20'b0, addra}, {20'b0, wr_q[0].idx});
                    check("dina", dina, wr_q[0].data);
                    void'(wr_q.pop_front());
                end
            end else if (dp == 2) begin
                if (rd_q.size() == 0) begin
                    check("rd_q_underflow", rd_q.size(), 32'd1);
                end else if (rd_q[0].stall && !stall_seen) begin
                    check("stall_hreadyout", {31'b0, HREADYOUT}, 32'd0);
                    stall_seen = 1;
                end else begin
                    check("hreadyout", {31'b0, HREADYOUT}, 32'd1);
                    check("hrdata", HRDATA, rd_q[0].data);
                    check("hresp", {31'b0, HRESP}, 32'd0);
                    void'(rd_q.pop_front());
                    stall_seen = 0;
                end
            end else begin
                check("wea_idle", {28'b0, wea}, 32'd0);
            end
            if (HREADYOUT) dp = (HSEL && HTRANS[1]) ? (HWRITE ? 1 : 2) : 0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < (1 << AW); i++) begin
            ram[i]     = '0;
            ref_mem[i] = '0;
        end
        rst    = 1'b1;
        HSEL   = 1'b0;
        HADDR  = '0;
        HTRANS = 2'b00;
        HSIZE  = 3'd2;
        HWRITE = 1'b0;
        HWDATA = '0;
        repeat (3) @(posedge clka);
        @(negedge clka);
        check("rst_hreadyout", {31'b0, HREADYOUT}, 32'd1);
        check("rst_wea", {28'b0, wea}, 32'd0);
        check("rst_hrdata", HRDATA, 32'd0);
        check("rst_addra", {20'b0, addra}, 32'd0);
        check("rst_dina", dina, 32'd0);
        check("rst_hresp", {31'b0, HRESP}, 32'd0);
        @(posedge clka);
        #1;
        rst = 1'b0;

        // Word write, later read
        ahb(1, 2'b10, 1, 32'h10, 3'd2, 32'hDEADBEEF);
        idle();
        idle();
        ahb(1, 2'b10, 0, 32'h10, 3'd2, 32'h0);
        idle();

        // Byte then half write over the same word, then read
        ahb(1, 2'b10, 1, 32'h11, 3'd0, 32'h0000AA00);
        ahb(1, 2'b10, 1, 32'h12, 3'd1, 32'h55660000);
        idle();
        ahb(1, 2'b10, 0, 32'h10, 3'd2, 32'h0);
        idle();

        // Write immediately followed by read of the same word
        ahb(1, 2'b10, 1, 32'h20, 3'd2, 32'h12345678);
        ahb(1, 2'b10, 0, 32'h20, 3'd2, 32'h0);
        idle();

        // Byte lane 3 write then immediate read
        ahb(1, 2'b10, 1, 32'h23, 3'd0, 32'h99000000);
        ahb(1, 2'b10, 0, 32'h20, 3'd2, 32'h0);
        idle();

        // Upper address bits wrap
        ahb(1, 2'b10, 1, 32'h0000_4030, 3'd2, 32'hA5A50001);
        idle();
        ahb(1, 2'b10, 0, 32'h30, 3'd2, 32'h0);
        idle();

        // IDLE transfer with HSEL/HWRITE high must not write
        ahb(1, 2'b00, 1, 32'h44, 3'd2, 32'hBAD0BAD0);
        HWDATA = 32'hBAD0BAD0;
        idle();
        ahb(1, 2'b10, 0, 32'h44, 3'd2, 32'h0);
        idle();

        // Reset during a write address phase abandons the write
        HSEL   = 1'b1;
        HTRANS = 2'b10;
        HWRITE = 1'b1;
        HADDR  = 32'h40;
        HSIZE  = 3'd2;
        rst    = 1'b1;
        @(posedge clka);
        #1;
        rst    = 1'b0;
        HSEL   = 1'b0;
        HTRANS = 2'b00;
        HWDATA = 32'hCAFEF00D;
        @(negedge clka);
        check("wea_after_rst", {28'b0, wea}, 32'd0);
        @(posedge clka);
        #1;
        pend_wdata = '0;
        prev_wr    = 0;
        ahb(1, 2'b10, 0, 32'h40, 3'd2, 32'h0);
        idle();

        // Random mix on a small window to provoke hazards and back-to-back traffic
        for (int i = 0; i < 60; i++) begin
            int unsigned op;
            int unsigned sz;
            logic [31:0] a;
            logic [31:0] d;
            op = $urandom_range(0, 4);
            sz = $urandom_range(0, 2);
            a  = 32'h100 + ($urandom_range(0, 3) << 2);
            if (sz == 0) a[1:0] = 2'($urandom_range(0, 3));
            if (sz == 1) a[1]   = 1'($urandom_range(0, 1));
            d = $urandom;
            if (op == 0) begin
                idle();
            end else begin
                ahb(1, $urandom_range(0, 1) ? 2'b10 : 2'b11, op > 2, a, 3'(sz), d);
            end
        end
        repeat (4) idle();

        check("wr_q_drained", wr_q.size(), 32'd0);
        check("rd_q_drained", rd_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
